// File: rtl/comp_limiter_if.sv
// comp_limiter sample bus: input/output valid-ready pair plus control.
// Optional makeup_gain member under COMP_MAKEUP_GAIN_EN.
interface comp_limiter_if;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] signal_in;
  logic               enable;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] signal_out;
  logic [15:0]        gain_out;
`ifdef COMP_MAKEUP_GAIN_EN
  logic [15:0]        makeup_gain;

  modport master (
    output in_valid, signal_in, enable,
    output out_ready, makeup_gain,
    input  in_ready, out_valid,
    input  signal_out, gain_out
  );
  modport slave (
    input  in_valid, signal_in, enable,
    input  out_ready, makeup_gain,
    output in_ready, out_valid,
    output signal_out, gain_out
  );
`else
  modport master (
    output in_valid, signal_in, enable,
    output out_ready,
    input  in_ready, out_valid,
    input  signal_out, gain_out
  );
  modport slave (
    input  in_valid, signal_in, enable,
    input  out_ready,
    output in_ready, out_valid,
    output signal_out, gain_out
  );
`endif
endinterface

// File: rtl/comp_limiter.sv
// Envelope-following limiter, gain from a restoring divider.
// Optional Q.4 makeup gain stage enabled by COMP_MAKEUP_GAIN_EN.
module comp_limiter #(
  parameter int bits_per_level = 12,
  parameter int gain_frac_bits = 8,
  parameter int attack_shift   = 2,
  parameter int release_shift  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  comp_limiter_if.slave bus
);
  localparam logic [16:0] THR   = 17'(1 << bits_per_level);
  localparam logic [15:0] UNITY = 16'(1 << gain_frac_bits);
  localparam int          CW    = $clog2(gain_frac_bits + 1);
  localparam logic [CW-1:0] CLAST = CW'(gain_frac_bits - 1);

  typedef enum logic [2:0] {
    IDLE, ENV, DIV, APPLY, OUT
  } state_t;

  state_t             state_q, state_d;
  logic signed [15:0] smp_q;
  logic [15:0]        env_q;
  logic [16:0]        rem_q;
  logic [15:0]        gain_q;
  logic [CW-1:0]      cnt_q;
  logic               ov_q;
  logic signed [15:0] sout_q;
  logic [15:0]        gout_q;

  logic [15:0]        abs_w, diff_w, inc_w, env_nxt;
  logic               comp_w;
  logic [16:0]        rem_sh;
  logic               ge_w;
  logic signed [32:0] prod_w, res_w;
  logic signed [15:0] out_w;

  function automatic logic signed [15:0] sat16(
    input logic signed [32:0] v
  );
    if (v > 33'sd32767)       return 16'sh7fff;
    else if (v < -33'sd32768) return 16'sh8000;
    else                      return v[15:0];
  endfunction

  always_comb begin
    abs_w  = smp_q[15] ? (~smp_q + 16'd1) : smp_q;
    diff_w = abs_w - env_q;
    inc_w  = diff_w >> attack_shift;
    if (inc_w == 16'd0) inc_w = 16'd1;
    if (abs_w > env_q) env_nxt = env_q + inc_w;
    else env_nxt = env_q - (env_q >> release_shift);
    comp_w = bus.enable && ({1'b0, env_nxt} > THR);
    rem_sh = {rem_q[15:0], 1'b0};
    ge_w   = rem_sh >= {1'b0, env_q};
  end

  // Floor product, saturate, then optionally scale by makeup.
  always_comb begin
    prod_w = 33'(smp_q) * $signed({17'd0, gain_q});
    res_w  = prod_w >>> gain_frac_bits;
    out_w  = sat16(res_w);
`ifdef COMP_MAKEUP_GAIN_EN
    prod_w = 33'(out_w) * $signed({17'd0, bus.makeup_gain});
    out_w  = sat16(prod_w >>> 4);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.in_valid) state_d = ENV;
      ENV:     state_d = comp_w ? DIV : APPLY;
      DIV:     if (cnt_q == CLAST) state_d = APPLY;
      APPLY:   state_d = OUT;
      OUT:     if (bus.out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready   = rst_n && (state_q == IDLE);
    bus.out_valid  = ov_q;
    bus.signal_out = sout_q;
    bus.gain_out   = gout_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_q  <= '0;
      env_q  <= '0;
      rem_q  <= '0;
      gain_q <= '0;
      cnt_q  <= '0;
      ov_q   <= 1'b0;
      sout_q <= '0;
      gout_q <= UNITY;
    end else begin
      unique case (state_q)
        IDLE: if (bus.in_valid) smp_q <= bus.signal_in;
        ENV: begin
          env_q  <= env_nxt;
          rem_q  <= THR;
          cnt_q  <= '0;
          gain_q <= comp_w ? 16'd0 : UNITY;
        end
        DIV: begin
          rem_q  <= ge_w ? (rem_sh - {1'b0, env_q}) : rem_sh;
          gain_q <= {gain_q[14:0], ge_w};
          cnt_q  <= cnt_q + 1'b1;
        end
        APPLY: begin
          sout_q <= out_w;
          gout_q <= gain_q;
          ov_q   <= 1'b1;
        end
        OUT: if (bus.out_ready) ov_q <= 1'b0;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_comp_limiter.sv
// Directed scoreboard bench for comp_limiter.
// Makeup steps run only when COMP_MAKEUP_GAIN_EN is defined.
module tb_comp_limiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  int   acc_cyc = 0;

  typedef struct {
    int s;
    int g;
    int lat;
  } exp_t;
  exp_t sb[$];

  comp_limiter_if bus();

  comp_limiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(string tag, logic signed [31:0] obs,
                     logic signed [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send(int smp, int es, int eg, int el);
    int k;
    @(negedge clk);
    for (k = 0; k < 50 && !bus.in_ready; k++) @(negedge clk);
    if (k == 50) chk("in_ready_timeout", 0, 1);
    bus.signal_in = 16'(smp);
    bus.in_valid  = 1'b1;
    sb.push_back('{es, eg, el});
    @(posedge clk);
    #1 acc_cyc = cyc;
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(string tag, int hold);
    exp_t e;
    int   k;
    for (k = 0; k < 50 && !bus.out_valid; k++) @(negedge clk);
    e = sb.pop_front();
    if (k == 50) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    chk({tag, "_lat"}, cyc - acc_cyc, e.lat);
    chk({tag, "_sig"}, bus.signal_out, e.s);
    chk({tag, "_gain"}, bus.gain_out, e.g);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk({tag, "_hold_v"}, bus.out_valid, 1);
      chk({tag, "_hold_s"}, bus.signal_out, e.s);
      chk({tag, "_hold_g"}, bus.gain_out, e.g);
      chk({tag, "_hold_rdy"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 chk({tag, "_clr"}, bus.out_valid, 0);
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.in_valid  = 1'b1;
    bus.signal_in = 16'sd1234;
    bus.enable    = 1'b1;
    bus.out_ready = 1'b0;
`ifdef COMP_MAKEUP_GAIN_EN
    bus.makeup_gain = 16'd16;
`endif
    repeat (3) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_signal_out", bus.signal_out, 0);
    chk("rst_gain_out", bus.gain_out, 256);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);

    send(1000, 1000, 256, 2);
    recv("below", 0);

    do_reset();
    send(16384, 16384, 256, 2);
    recv("comp1", 0);
    send(16384, 9344, 146, 10);
    recv("comp2", 0);
    send(-32768, -9856, 77, 10);
    recv("negfs", 5);
    send(0, 0, 77, 10);
    recv("zero", 0);

    bus.enable = 1'b0;
    send(16384, 16384, 256, 2);
    recv("dis", 0);
    bus.enable = 1'b1;
    send(8192, 2336, 73, 10);
    recv("reen", 0);

    do_reset();
    send(16384, 9344, 146, 10);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_ov", bus.out_valid, 0);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_none", bus.out_valid, 0);
    chk("abort_rdy", bus.in_ready, 1);
    void'(sb.pop_front());

`ifdef COMP_MAKEUP_GAIN_EN
    do_reset();
    bus.makeup_gain = 16'd32;
    send(1000, 2000, 256, 2);
    recv("mk32", 0);
    bus.makeup_gain = 16'd240;
    send(3000, 32767, 256, 2);
    recv("mk240", 0);
`endif

    chk("sb_empty", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end
endmodule
